fetch_npc_ctrl: RTL

- Consumer side of the program-counter register. It takes the current `pc`, fetches the instruction at that address from instruction memory over a req/gnt/rvalid handshake, and presents it to decode over a valid/ready handshake.
- It drives the `npc` value that the PC register loads unconditionally every cycle. It holds the PC while a fetch is in flight, advances it by 4 on delivery, and jumps on redirect.

---
 rtl/fetch_npc_ctrl_pkg.sv | 15 +
 rtl/fetch_npc_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/fetch_npc_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch / next-PC controller.
package fetch_npc_ctrl_pkg;

  localparam int          XLEN_DEF       = 32;
  localparam int          INST_BYTES_DEF = 4;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_npc_ctrl.sv
// Fetch controller: issues one imem read per PC, hands the word to decode and
// steers the next-PC value (hold / +INST_BYTES / redirect) that the PC register loads.
module fetch_npc_ctrl
  import fetch_npc_ctrl_pkg::*;
#(
  parameter int             XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
  parameter int             INST_BYTES = INST_BYTES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] npc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target
);

  fetch_state_e    state;
  logic            kill;
  logic [XLEN-1:0] addr_q;
  logic            accept;

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign accept    = (state == HOLD) && inst_ready && !redirect_valid;

  // Redirect outranks the sequential advance; otherwise the PC simply holds.
  always_comb begin
    npc = pc;
    if (rst) begin
      npc = RESET_PC;
    end else if (redirect_valid) begin
      npc = redirect_target;
    end else if (accept) begin
      npc = pc + XLEN'(INST_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      kill       <= 1'b0;
      addr_q     <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= REQ;
        end

        REQ: begin
          if (imem_gnt) begin
            addr_q <= pc;
            state  <= WAIT;
            // A grant that coincides with a redirect is still outstanding and must be drained.
            if (redirect_valid) begin
              kill <= 1'b1;
            end
          end
        end

        WAIT: begin
          if (imem_rvalid) begin
            if (kill || redirect_valid) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              inst       <= imem_rdata;
              inst_pc    <= addr_q;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end else if (redirect_valid) begin
            kill <= 1'b1;
          end
        end

        HOLD: begin
          if (redirect_valid || inst_ready) begin
            inst_valid <= 1'b0;
            state      <= REQ;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
